// File: rtl/lt24_pixel_sink.sv
// ============================================================================
// Module   : lt24_pixel_sink
// Purpose  : Responder model of the LT24 pixel port. Checks raster order,
//            counts pixels and signs each frame with a CRC-16-CCITT.
//            Optional macro: PIXEL_SINK_CRC_EN (CRC logic present when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lt24_pixel_sink #(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int INIT_CYCLES = 16,
    parameter int READY_GAP   = 3
) (
    input  logic        clock,
    input  logic        globalReset,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        resetApp,
    output logic        frameDone,
    output logic [15:0] frameCrc,
    output logic [16:0] framePixels,
    output logic        seqError,
    output logic        rangeError
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int GW = (READY_GAP > 1) ? $clog2(READY_GAP) : 1;
    localparam logic [IW-1:0] c_init_last = IW'(INIT_CYCLES - 1);
    localparam logic [GW-1:0] c_gap_last  = GW'((READY_GAP > 0) ? READY_GAP - 1 : 0);
    localparam bit            c_has_gap   = (READY_GAP > 0);
    localparam logic [8:0]    c_width     = 9'(WIDTH);
    localparam logic [9:0]    c_height    = 10'(HEIGHT);
    localparam logic [7:0]    c_x_last    = 8'(WIDTH - 1);
    localparam logic [8:0]    c_y_last    = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_init_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [7:0]      r_ex;
    logic [8:0]      r_ey;
    logic [16:0]     r_cnt;

    logic w_accept;
    logic w_in_range;
    logic w_x_last;
    logic w_frame_end;

    assign w_accept    = pixelReady & pixelWrite;
    assign w_in_range  = ({1'b0, xAddr} < c_width) && ({1'b0, yAddr} < c_height);
    assign w_x_last    = (xAddr == c_x_last);
    assign w_frame_end = w_x_last && (yAddr == c_y_last);

    always_ff @(posedge clock) begin
        if (!globalReset) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_ex        <= '0;
            r_ey        <= '0;
            r_cnt       <= '0;
            pixelReady  <= 1'b0;
            resetApp    <= 1'b1;
            frameDone   <= 1'b0;
            framePixels <= '0;
            seqError    <= 1'b0;
            rangeError  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == c_init_last) begin
                        resetApp   <= 1'b0;
                        pixelReady <= 1'b1;
                        r_state    <= S_READY;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (w_accept && c_has_gap) begin
                        pixelReady <= 1'b0;
                        r_gap_cnt  <= '0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        pixelReady <= 1'b1;
                        r_state    <= S_READY;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_INIT;
            endcase

            if (w_accept) begin
                if (w_in_range) begin
                    if ((xAddr != r_ex) || (yAddr != r_ey))
                        seqError <= 1'b1;
                    // Expected address follows the received pixel, not the old expectation
                    if (w_frame_end) begin
                        framePixels <= r_cnt + 17'd1;
                        r_cnt       <= '0;
                        frameDone   <= 1'b1;
                        r_ex        <= '0;
                        r_ey        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                        if (w_x_last) begin
                            r_ex <= '0;
                            r_ey <= yAddr + 1'b1;
                        end else begin
                            r_ex <= xAddr + 1'b1;
                        end
                    end
                end else begin
                    rangeError <= 1'b1;
                end
            end
        end
    end

`ifdef PIXEL_SINK_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    // Whole 16-bit word absorbed MSB first in a single cycle
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 15; i >= 0; i--) begin
            if (w_crc_next[15] ^ pixelData[i])
                w_crc_next = {w_crc_next[14:0], 1'b0} ^ 16'h1021;
            else
                w_crc_next = {w_crc_next[14:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (!globalReset) begin
            r_crc    <= 16'hFFFF;
            frameCrc <= '0;
        end else if (w_accept && w_in_range) begin
            if (w_frame_end) begin
                frameCrc <= w_crc_next;
                r_crc    <= 16'hFFFF;
            end else begin
                r_crc <= w_crc_next;
            end
        end
    end
`else
    logic w_unused_data;
    assign w_unused_data = ^pixelData;
    assign frameCrc      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lt24_pixel_sink.sv
// ============================================================================
// Module   : tb_lt24_pixel_sink
// Purpose  : Directed self-checking bench for lt24_pixel_sink on a 20x10 raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lt24_pixel_sink;

    localparam int W  = 20;
    localparam int H  = 10;
    localparam int IC = 16;
    localparam int RG = 3;

    logic        clock = 1'b0;
    logic        globalReset = 1'b0;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady;
    logic        resetApp;
    logic        frameDone;
    logic [15:0] frameCrc;
    logic [16:0] framePixels;
    logic        seqError;
    logic        rangeError;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    lt24_pixel_sink #(
        .WIDTH(W), .HEIGHT(H), .INIT_CYCLES(IC), .READY_GAP(RG)
    ) dut (
        .clock(clock), .globalReset(globalReset), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .resetApp(resetApp), .frameDone(frameDone), .frameCrc(frameCrc),
        .framePixels(framePixels), .seqError(seqError), .rangeError(rangeError)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (frameDone === 1'b1) done_cnt++;

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Expected frameCrc of a full frame with data x^y, one pixel optionally XORed with flip
    function automatic logic [15:0] exp_crc(input int fx, input int fy, input logic [15:0] flip);
        logic [15:0] c;
        logic [15:0] d;
        c = 16'hFFFF;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                d = 16'(x ^ y);
                if (x == fx && y == fy) d = d ^ flip;
                c = crc_word(c, d);
            end
`ifdef PIXEL_SINK_CRC_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic do_reset();
        globalReset = 1'b0;
        pixelWrite  = 1'b0;
        repeat (3) @(negedge clock);
        globalReset = 1'b1;
    endtask

    task automatic send_pixel(input int x, input int y, input logic [15:0] d);
        int n;
        n = 0;
        while (pixelReady !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (pixelReady !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout pixelReady=%b required 1", pixelReady);
        end else begin
            xAddr = 8'(x); yAddr = 9'(y); pixelData = d; pixelWrite = 1'b1;
            @(negedge clock);
            pixelWrite = 1'b0;
        end
    endtask

    task automatic send_range(input int first, input int last, input int fx, input int fy,
                              input logic [15:0] flip);
        logic [15:0] d;
        for (int i = first; i < last; i++) begin
            d = 16'((i % W) ^ (i / W));
            if ((i % W) == fx && (i / W) == fy) d = d ^ flip;
            send_pixel(i % W, i / W, d);
        end
    endtask

    task automatic test_reset();
        globalReset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (pixelReady !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", pixelReady); end
        checks++; if (resetApp !== 1'b1) begin errors++; $display("FAIL rst_resetApp got=%b want=1", resetApp); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", frameDone); end
        checks++; if (frameCrc !== 16'h0) begin errors++; $display("FAIL rst_crc got=%h want=0000", frameCrc); end
        checks++; if (framePixels !== 17'd0) begin errors++; $display("FAIL rst_pixels got=%0d want=0", framePixels); end
        checks++; if (seqError !== 1'b0) begin errors++; $display("FAIL rst_seq got=%b want=0", seqError); end
        checks++; if (rangeError !== 1'b0) begin errors++; $display("FAIL rst_range got=%b want=0", rangeError); end
    endtask

    task automatic test_init();
        int hi;
        int bad_ready;
        hi = 0; bad_ready = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (resetApp !== 1'b1) break;
            hi++;
            if (pixelReady !== 1'b0) bad_ready++;
            @(negedge clock);
        end
        checks++; if (hi != IC) begin errors++; $display("FAIL init_len got=%0d want=%0d", hi, IC); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL init_ready_early got=%0d want=0", bad_ready); end
        checks++; if (pixelReady !== 1'b1) begin errors++; $display("FAIL init_ready_rise got=%b want=1", pixelReady); end
    endtask

    task automatic test_gap();
        int prev;
        int lows;
        int x;
        int accepts;
        bit adv;
        do_reset();
        for (int k = 0; k < 40 && pixelReady !== 1'b1; k++) @(negedge clock);
        prev = -1; lows = 0; x = 0; adv = 0; accepts = 0;
        xAddr = 8'd0; yAddr = 9'd0; pixelData = 16'h1234; pixelWrite = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (adv) begin x++; xAddr = 8'(x); adv = 0; end
            if (pixelReady === 1'b1) begin
                if (prev >= 0) begin
                    checks++; if (i - prev != RG + 1) begin errors++; $display("FAIL gap_spacing got=%0d want=%0d", i - prev, RG + 1); end
                    checks++; if (lows != RG) begin errors++; $display("FAIL gap_low got=%0d want=%0d", lows, RG); end
                end
                prev = i; lows = 0; adv = 1; accepts++;
            end else begin
                lows++;
            end
            @(negedge clock);
        end
        pixelWrite = 1'b0;
        checks++; if (accepts != 10) begin errors++; $display("FAIL gap_accepts got=%0d want=10", accepts); end
        checks++; if (seqError !== 1'b0) begin errors++; $display("FAIL gap_seq got=%b want=0", seqError); end
    endtask

    task automatic test_frame();
        int d0;
        logic [15:0] clean;
        clean = exp_crc(-1, -1, 16'h0);
        do_reset();
        d0 = done_cnt;
        send_range(0, W * H, -1, -1, 16'h0);
        checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL frame_done_pulse got=%b want=1", frameDone); end
        @(negedge clock);
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL frame_done_clear got=%b want=0", frameDone); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL frame_done_count got=%0d want=1", done_cnt - d0); end
        checks++; if (framePixels !== 17'(W * H)) begin errors++; $display("FAIL frame_pixels got=%0d want=%0d", framePixels, W * H); end
        checks++; if (frameCrc !== clean) begin errors++; $display("FAIL frame_crc got=%h want=%h", frameCrc, clean); end
        checks++; if (seqError !== 1'b0 || rangeError !== 1'b0) begin errors++; $display("FAIL frame_flags got=%b%b want=00", seqError, rangeError); end
        send_range(0, W * H, -1, -1, 16'h0);
        checks++; if (frameCrc !== clean) begin errors++; $display("FAIL frame2_crc got=%h want=%h", frameCrc, clean); end
        checks++; if (framePixels !== 17'(W * H)) begin errors++; $display("FAIL frame2_pixels got=%0d want=%0d", framePixels, W * H); end
        send_range(0, W * H, 3, 4, 16'h0100);
        checks++; if (frameCrc !== exp_crc(3, 4, 16'h0100)) begin errors++; $display("FAIL frame_flip_crc got=%h want=%h", frameCrc, exp_crc(3, 4, 16'h0100)); end
`ifdef PIXEL_SINK_CRC_EN
        checks++; if (frameCrc === clean) begin errors++; $display("FAIL frame_flip_differs got=%h want!=%h", frameCrc, clean); end
`endif
    endtask

    task automatic test_seq();
        do_reset();
        send_range(0, 3, -1, -1, 16'h0);
        checks++; if (seqError !== 1'b0) begin errors++; $display("FAIL seq_inorder got=%b want=0", seqError); end
        send_pixel(5, 0, 16'h0005);
        checks++; if (seqError !== 1'b1) begin errors++; $display("FAIL seq_skip got=%b want=1", seqError); end
        send_pixel(6, 0, 16'h0006);
        checks++; if (seqError !== 1'b1) begin errors++; $display("FAIL seq_sticky got=%b want=1", seqError); end
        send_range(7, W * H, -1, -1, 16'h0);
        checks++; if (framePixels !== 17'(W * H - 2)) begin errors++; $display("FAIL seq_pixels got=%0d want=%0d", framePixels, W * H - 2); end
        checks++; if (rangeError !== 1'b0) begin errors++; $display("FAIL seq_range got=%b want=0", rangeError); end
    endtask

    task automatic test_range();
        logic [15:0] clean;
        clean = exp_crc(-1, -1, 16'h0);
        do_reset();
        send_range(0, 2, -1, -1, 16'h0);
        checks++; if (rangeError !== 1'b0) begin errors++; $display("FAIL range_clean got=%b want=0", rangeError); end
        send_pixel(W, 0, 16'hABCD);
        checks++; if (rangeError !== 1'b1) begin errors++; $display("FAIL range_x got=%b want=1", rangeError); end
        send_pixel(0, H, 16'h5A5A);
        send_range(2, W * H, -1, -1, 16'h0);
        checks++; if (framePixels !== 17'(W * H)) begin errors++; $display("FAIL range_pixels got=%0d want=%0d", framePixels, W * H); end
        checks++; if (frameCrc !== clean) begin errors++; $display("FAIL range_crc got=%h want=%h", frameCrc, clean); end
        checks++; if (seqError !== 1'b0) begin errors++; $display("FAIL range_seq got=%b want=0", seqError); end
        checks++; if (rangeError !== 1'b1) begin errors++; $display("FAIL range_sticky got=%b want=1", rangeError); end
    endtask

    task automatic test_midreset();
        int d0;
        logic [15:0] clean;
        clean = exp_crc(-1, -1, 16'h0);
        do_reset();
        send_range(0, W * H, -1, -1, 16'h0);
        send_range(0, 100, -1, -1, 16'h0);
        send_pixel(50, 0, 16'h0);
        globalReset = 1'b0;
        @(negedge clock);
        checks++; if (pixelReady !== 1'b0 || resetApp !== 1'b1) begin errors++; $display("FAIL mid_handshake got=%b%b want=01", pixelReady, resetApp); end
        checks++; if (framePixels !== 17'd0) begin errors++; $display("FAIL mid_pixels got=%0d want=0", framePixels); end
        checks++; if (frameCrc !== 16'h0) begin errors++; $display("FAIL mid_crc got=%h want=0000", frameCrc); end
        checks++; if (seqError !== 1'b0 || rangeError !== 1'b0 || frameDone !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b%b%b want=000", seqError, rangeError, frameDone); end
        globalReset = 1'b1;
        d0 = done_cnt;
        send_range(0, W * H, -1, -1, 16'h0);
        @(negedge clock);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL mid_done got=%0d want=1", done_cnt - d0); end
        checks++; if (framePixels !== 17'(W * H)) begin errors++; $display("FAIL mid_frame_pixels got=%0d want=%0d", framePixels, W * H); end
        checks++; if (frameCrc !== clean) begin errors++; $display("FAIL mid_frame_crc got=%h want=%h", frameCrc, clean); end
        checks++; if (seqError !== 1'b0) begin errors++; $display("FAIL mid_frame_seq got=%b want=0", seqError); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_gap();
        test_frame();
        test_seq();
        test_range();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lt24_pixel_sink.md
# lt24_pixel_sink

Responder-side model of the LT24 pixel write interface: accepts the `xAddr`/`yAddr`/`pixelData`/`pixelWrite` stream a frame renderer produces and answers with `pixelReady` and `resetApp` exactly as the display controller's pixel port does. It stands in for the display controller in simulation and on-chip self-test. It checks raster order, counts pixels and produces a per-frame CRC, so renderer output can be verified without a panel attached.

## Interface
- `WIDTH`, default 240: pixels per line; valid x is 0..WIDTH-1.
- `HEIGHT`, default 320: lines per frame; valid y is 0..HEIGHT-1.
- `INIT_CYCLES`, default 16, minimum 1: number of cycles `resetApp` is held high after reset is released.
- `READY_GAP`, default 3, minimum 0: idle cycles with `pixelReady` low after each accepted pixel.
- `clock`  in  1: the single clock; all logic is on the rising edge.
- `globalReset`  in  1: synchronous, active-low reset.
- `xAddr`  in  8: pixel column.
- `yAddr`  in  9: pixel row.
- `pixelData`  in  16: RGB565 pixel value.
- `pixelWrite`  in  1: the renderer offers a pixel.
- `pixelReady`  out  1: the sink can take a pixel this cycle.
- `resetApp`  out  1: application reset; high during the init phase.
- `frameDone`  out  1: one-cycle pulse after the last pixel of a frame is accepted.
- `frameCrc`  out  16: CRC of the last completed frame.
- `framePixels`  out  17: in-range pixels accepted in the last completed frame.
- `seqError`  out  1: sticky flag; raster-order violation.
- `rangeError`  out  1: sticky flag; out-of-range address.

## Operation
- State machine states are INIT, READY and GAP.
- INIT:
  - `pixelReady`=0, `resetApp`=1, and a cycle counter increments.
  - On the edge that completes INIT_CYCLES cycles: `resetApp`<=0, `pixelReady`<=1, go to READY.
- READY:
  - `pixelReady`=1.
  - An accept is a cycle with `pixelReady`=1 and `pixelWrite`=1.
  - On accept with READY_GAP>0: `pixelReady`<=0, gap counter<=0, go to GAP.
  - On accept with READY_GAP=0: stay in READY.
- GAP:
  - `pixelReady`=0 and the gap counter increments.
  - When READY_GAP cycles have elapsed: `pixelReady`<=1, go to READY.
  - `pixelWrite` is ignored while `pixelReady`=0.
- Expected address (ex, ey) is 0,0 after reset.
- On accept of an in-range address:
  - If (x,y) differs from (ex,ey), set `seqError`.
  - The expected address then resyncs to the raster successor of the received (x,y): x+1, or 0 and y+1 at x=WIDTH-1, or 0,0 after (WIDTH-1,HEIGHT-1).
  - The running CRC absorbs `pixelData`, and the pixel counter increments.
- On accept of an out-of-range address (x≥WIDTH or y≥HEIGHT):
  - Set `rangeError`.
  - The pixel is excluded from the CRC and the count, and the expected address is unchanged.
- Frame end is an accept at (WIDTH-1, HEIGHT-1):
  - Next edge: `frameCrc` <= CRC including this pixel, `framePixels` <= count including this pixel, `frameDone`<=1 for one cycle.
  - The running CRC reloads 0xFFFF and the counter reloads 0.
- CRC is CRC-16-CCITT: polynomial 0x1021, seed 0xFFFF, no reflection, no final XOR. All 16 data bits are processed MSB first in one cycle.
- Simultaneous events: a frame-end pixel that is also out of sequence sets `seqError` and still completes the frame.
- Error flags are sticky and clear only on reset.

## Timing
- Reset values:
  - `pixelReady`=0, `resetApp`=1, `frameDone`=0, `frameCrc`=0, `framePixels`=0, `seqError`=0, `rangeError`=0.
  - State INIT, expected address 0,0, running CRC 0xFFFF.
- Reset is sampled every edge. Asserting it mid-frame or mid-gap discards the partial frame and restarts INIT.
- `resetApp` is high for exactly INIT_CYCLES cycles after the first edge with `globalReset`=1.
- All outputs are registered.
- Minimum spacing between accepts is READY_GAP+1 cycles.
- Flags, `frameCrc` and `framePixels` update on the edge after the accept cycle.

## Configuration
- `PIXEL_SINK_CRC_EN` defined: CRC logic is present and `frameCrc` behaves as specified above.
- `PIXEL_SINK_CRC_EN` undefined: no CRC logic and `frameCrc` is constant 0. Handshake, `framePixels`, `frameDone` and the error flags are unchanged.

## Test plan
- Reset release with INIT_CYCLES=16 -> `resetApp` is high for exactly 16 cycles, and `pixelReady` rises on the same edge that `resetApp` falls.
- `pixelWrite` held at 1 with READY_GAP=3 -> accepts occur every 4 cycles, and `pixelReady` is low for 3 cycles between accepts.
- Full 240×320 raster with `pixelData`=x^y -> one `frameDone` pulse, `framePixels`=76800, `frameCrc` matches a bit-serial model, no errors. A second identical frame gives the same CRC; flipping a single bit changes it.
- Pixel (5,0) sent after (2,0) -> `seqError`=1 and the expected address becomes (6,0). (6,0) next raises no new error, and the flag stays set.
- Address (240,0) accepted -> `rangeError`=1, and the count and CRC are unchanged.
- Reset asserted mid-frame at pixel 1000 -> all outputs return to reset values and the next frame is counted from 0; repeat with the macro undefined and check `frameCrc`=0.
